// File: rtl/gauss_clt_acc.sv
// gauss_clt_acc: approximate Gaussian sample generator.
// It sums NSUM uniforms taken from the urng tau word, using the central limit theorem,
// and removes the mean to give a signed sample. Results go into a 2-entry FIFO that the
// sink reads with valid/ready. A local 2-bit phase counter follows the urng update
// cadence. The shared ST pulse aligns this counter with the urng.
module gauss_clt_acc #(
    parameter  int NSUM = 4,                    // uniforms per sample, power of 2, 2..16
    parameter  int UW   = 12,                   // uniform width taken from the top of u_in
    localparam int OW   = UW + $clog2(NSUM) + 1 // signed output width
) (
    input  logic          CK,
    input  logic          RB,
    input  logic          ST,
    input  logic [31:0]   u_in,
    output logic [OW-1:0] out_dat,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [7:0]    drop_cnt,
    output logic          busy
);

    localparam int LW = $clog2(NSUM);
    localparam int AW = UW + LW;
    // Mean of the sum of NSUM uniforms. Subtracting it centres the result on zero.
    localparam logic [OW-1:0] C_OFFSET = OW'(NSUM * (1 << (UW - 1)));

    typedef enum logic {S_IDLE, S_ACC} state_t;

    state_t          r_state;
    logic [1:0]      r_phase;
    logic [AW-1:0]   r_acc;
    logic [LW-1:0]   r_nsamp;
    logic [OW-1:0]   r_ent0;     // FIFO head
    logic [OW-1:0]   r_ent1;     // FIFO second entry
    logic [1:0]      r_cnt;      // FIFO occupancy, 0..2
    logic [7:0]      r_drop;

    logic [UW-1:0]   w_u;
    logic [AW-1:0]   w_sum;
    logic [OW-1:0]   w_result;
    logic            w_sample;
    logic            w_last;
    logic            w_push;
    logic            w_pop;
    logic            w_unused;

    assign w_u      = u_in[31:32-UW];
    assign w_unused = &{1'b0, u_in[31-UW:0]};
    // The sum of NSUM uniforms fits in AW bits, so this addition never wraps.
    assign w_sum    = r_acc + AW'(w_u);
    assign w_result = {1'b0, w_sum} - C_OFFSET;

    // The urng updates on the edge after phase 3. This edge captures the word it held just before.
    assign w_sample = (r_state == S_ACC) && (r_phase == 2'd3) && !ST;
    assign w_last   = (r_nsamp == LW'(NSUM - 1));
    assign w_push   = w_sample && w_last;
    assign w_pop    = (r_cnt != 2'd0) && out_rdy;

    // FSM, phase tracking, accumulation and FIFO management in one registered process
    // NOTE: every register here uses non-blocking assignments. All next-state values
    // therefore come from pre-edge values, whatever order the statements appear in.
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_state <= S_IDLE;
            r_phase <= 2'd0;
            r_acc   <= '0;
            r_nsamp <= '0;
            // NOTE: the two FIFO entries are reset explicitly. Two words are cheap, and
            // keeping the unused slots at zero lets out_dat read 0 when the FIFO is empty
            // without an extra output mux.
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_cnt   <= 2'd0;
            r_drop  <= 8'd0;
        end else if (ST) begin
            // Start or restart. ST has priority over any sample or push on this edge.
            r_state <= S_ACC;
            r_phase <= 2'd0;
            r_acc   <= '0;
            r_nsamp <= '0;
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_cnt   <= 2'd0;
            r_drop  <= 8'd0;
        end else begin
            r_phase <= r_phase + 2'd1;

            if (w_sample) begin
                if (w_last) begin
                    r_acc   <= '0;
                    r_nsamp <= '0;
                end else begin
                    r_acc   <= w_sum;
                    r_nsamp <= r_nsamp + LW'(1);
                end
            end

            if (w_push && w_pop) begin
                // A simultaneous push and pop keeps the occupancy unchanged.
                if (r_cnt == 2'd2) begin
                    r_ent0 <= r_ent1;
                    r_ent1 <= w_result;
                end else begin
                    r_ent0 <= w_result;
                end
            end else if (w_push) begin
                case (r_cnt)
                    2'd0: begin
                        r_ent0 <= w_result;
                        r_cnt  <= 2'd1;
                    end
                    2'd1: begin
                        r_ent1 <= w_result;
                        r_cnt  <= 2'd2;
                    end
                    default: begin
                        if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
                    end
                endcase
            end else if (w_pop) begin
                r_ent0 <= r_ent1;
                r_ent1 <= '0;
                r_cnt  <= r_cnt - 2'd1;
            end
        end
    end

    assign out_dat  = r_ent0;
    assign out_vld  = (r_cnt != 2'd0);
    assign drop_cnt = r_drop;
    assign busy     = (r_state == S_ACC);

endmodule
